// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, read-mode enum and pointer-compare helpers for
// the single-clock and dual-clock FIFO families.
//   FIFO_DSIZE / FIFO_ASIZE : default data / address widths
//   fifo_mode_e             : STD (registered read) or FWFT (fall-through)
//   ptr_full / ptr_empty    : compare two (asize+1)-bit binary pointers
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  // Pointers are passed zero-extended to 32 bits so one helper serves any
  // ASIZE; only the low asize+1 bits take part in the compare.
  function automatic logic ptr_full(input logic [31:0] wptr,
                                    input logic [31:0] rptr,
                                    input int          asize);
    logic [31:0] mask;
    mask = (32'd1 << (asize + 1)) - 32'd1;
    // MSB differs, lower bits equal -> writer is one lap ahead.
    return ((wptr ^ rptr) & mask) == (32'd1 << asize);
  endfunction

  function automatic logic ptr_empty(input logic [31:0] wptr,
                                     input logic [31:0] rptr,
                                     input int          asize);
    logic [31:0] mask;
    mask = (32'd1 << (asize + 1)) - 32'd1;
    return ((wptr ^ rptr) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2**ASIZE x DSIZE register array.
//   clk   : write clock
//   wen   : write enable, waddr/wdata written on rising edge
//   raddr : asynchronous read address, rdata = mem[raddr]
// Contents are not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] r_mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (wen) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo2.sv
// sync_fifo2: single-clock FIFO with optional first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
//   clk, rst          : clock, async active-high reset
//   winc, wdata       : write request / data; wfull, walmost_full status
//   rinc, rdata       : read request (pop in FWFT) / data; rempty,
//                       ralmost_empty status
//   count             : occupancy 0..2**ASIZE
//   overflow/underflow: sticky, set by a write while full / read while empty
// All status is derived from the registered pointers, so it reflects an
// accepted transfer one cycle after the accepting edge.
module sync_fifo2
  import fifo_pkg::*;
#(
  parameter int DSIZE    = FIFO_DSIZE,
  parameter int ASIZE    = FIFO_ASIZE,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 2**ASIZE - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam fifo_mode_e       LP_MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  localparam logic [ASIZE:0]   LP_AF   = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0]   LP_AE   = (ASIZE+1)'(AE_LEVEL);

  if (AF_LEVEL < 0 || AF_LEVEL > 2**ASIZE ||
      AE_LEVEL < 0 || AE_LEVEL > 2**ASIZE) begin : g_bad_level
    $error("sync_fifo2: AF_LEVEL/AE_LEVEL must lie in 0..2**ASIZE");
  end

  logic [ASIZE:0]   r_wptr, r_rptr;
  logic             r_overflow, r_underflow;
  logic             w_full, w_empty, w_wacc, w_racc;
  logic [DSIZE-1:0] w_mem_rdata;

  assign w_full  = ptr_full(32'(r_wptr), 32'(r_rptr), ASIZE);
  assign w_empty = ptr_empty(32'(r_wptr), 32'(r_rptr), ASIZE);
  assign w_wacc  = winc && !w_full;
  assign w_racc  = rinc && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wacc)          r_wptr      <= r_wptr + 1'b1;
      if (w_racc)          r_rptr      <= r_rptr + 1'b1;
      if (winc && w_full)  r_overflow  <= 1'b1;
      if (rinc && w_empty) r_underflow <= 1'b1;
    end
  end

  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (clk),
    .wen   (w_wacc),
    .waddr (r_wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (r_rptr[ASIZE-1:0]),
    .rdata (w_mem_rdata)
  );

  if (LP_MODE == fifo_pkg::FWFT) begin : g_fwft
    // Head word shown directly; forced to 0 while empty so the output is
    // deterministic out of reset.
    assign rdata = w_empty ? '0 : w_mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] r_rdata;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_rdata <= '0;
      else if (w_racc) r_rdata <= w_mem_rdata;
    end
    assign rdata = r_rdata;
  end

  assign count         = r_wptr - r_rptr;
  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (count >= LP_AF);
  assign ralmost_empty = (count <= LP_AE);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo2.sv
module tb_sync_fifo2;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // standard-mode instance
  logic          s_winc = 0, s_rinc = 0;
  logic [DW-1:0] s_wdata = '0, s_rdata;
  logic          s_wfull, s_waf, s_rempty, s_rae, s_ovf, s_unf;
  logic [AW:0]   s_count;
  // FWFT instance
  logic          f_winc = 0, f_rinc = 0;
  logic [DW-1:0] f_wdata = '0, f_rdata;
  logic          f_wfull, f_waf, f_rempty, f_rae, f_ovf, f_unf;
  logic [AW:0]   f_count;

  sync_fifo2 #(.DSIZE(DW), .ASIZE(AW), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .winc(s_winc), .wdata(s_wdata), .wfull(s_wfull),
    .walmost_full(s_waf), .rinc(s_rinc), .rdata(s_rdata), .rempty(s_rempty),
    .ralmost_empty(s_rae), .count(s_count), .overflow(s_ovf), .underflow(s_unf));

  sync_fifo2 #(.DSIZE(DW), .ASIZE(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull),
    .walmost_full(f_waf), .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty),
    .ralmost_empty(f_rae), .count(f_count), .overflow(f_ovf), .underflow(f_unf));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_winc = 0; s_rinc = 0; f_winc = 0; f_rinc = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] popped;
  logic          m_ovf, m_unf, wacc, racc, wi, ri;
  logic [DW-1:0] wd;

  initial begin
    // ---------------- reset ----------------
    do_reset();
    chk("rst_count",  32'(s_count), 0);
    chk("rst_rempty", 32'(s_rempty), 1);
    chk("rst_wfull",  32'(s_wfull), 0);
    chk("rst_rae",    32'(s_rae), 1);
    chk("rst_waf",    32'(s_waf), 0);
    chk("rst_ovf",    32'(s_ovf), 0);
    chk("rst_unf",    32'(s_unf), 0);
    chk("rst_rdata",  32'(s_rdata), 0);
    chk("rst_f_rempty", 32'(f_rempty), 1);

    // ---------------- fill to full ----------------
    for (int i = 0; i < 16; i++) begin
      s_winc = 1; s_wdata = DW'(i);
      step();
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_waf",   32'(s_waf),   (i + 1 >= 14) ? 1 : 0);
      chk("fill_wfull", 32'(s_wfull), (i + 1 == 16) ? 1 : 0);
    end
    s_wdata = 8'hAA;
    step();
    s_winc = 0;
    chk("ovf_set",   32'(s_ovf), 1);
    chk("ovf_count", 32'(s_count), 16);
    for (int i = 0; i < 16; i++) begin
      s_rinc = 1;
      step();
      chk("drain_rdata", 32'(s_rdata), 32'(i));
    end
    s_rinc = 0;
    chk("drain_empty", 32'(s_rempty), 1);
    chk("drain_wfull", 32'(s_wfull), 0);

    // ---------------- underflow ----------------
    s_rinc = 1;
    step();
    s_rinc = 0;
    chk("unf_set",   32'(s_unf), 1);
    chk("unf_rdata", 32'(s_rdata), 32'h0F);
    chk("unf_count", 32'(s_count), 0);
    s_winc = 1; s_wdata = 8'h5A;
    step();
    s_winc = 0;
    chk("unf_wr_rempty", 32'(s_rempty), 0);
    chk("unf_wr_count",  32'(s_count), 1);
    s_rinc = 1;
    step();
    s_rinc = 0;
    chk("unf_rd_5a", 32'(s_rdata), 32'h5A);

    // ---------------- simultaneous r/w at count 8 ----------------
    for (int i = 0; i < 8; i++) begin
      s_winc = 1; s_wdata = DW'(8'h10 + i);
      step();
    end
    chk("sim_pre_count", 32'(s_count), 8);
    s_rinc = 1;
    for (int j = 0; j < 20; j++) begin
      s_wdata = DW'(8'h18 + j);
      step();
      chk("sim_count", 32'(s_count), 8);
      chk("sim_rdata", 32'(s_rdata), 32'(8'h10 + j));
    end
    s_winc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sim_drain", 32'(s_rdata), 32'(8'h24 + i));
    end
    s_rinc = 0;
    chk("sim_empty", 32'(s_rempty), 1);

    // ---------------- FWFT directed ----------------
    f_winc = 1; f_wdata = 8'h3C;
    step();
    f_winc = 0;
    chk("fw_rempty", 32'(f_rempty), 0);
    chk("fw_head",   32'(f_rdata), 32'h3C);
    f_winc = 1; f_wdata = 8'h3D;
    step();
    f_winc = 0;
    chk("fw_head_hold", 32'(f_rdata), 32'h3C);
    f_rinc = 1;
    step();
    f_rinc = 0;
    chk("fw_pop1", 32'(f_rdata), 32'h3D);
    chk("fw_pop1_empty", 32'(f_rempty), 0);
    f_rinc = 1;
    step();
    f_rinc = 0;
    chk("fw_pop2_empty", 32'(f_rempty), 1);

    // ---------------- random scoreboard, both modes ----------------
    do_reset();
    q.delete();
    m_ovf = 0; m_unf = 0;
    for (int c = 0; c < 5000; c++) begin
      wi = ($urandom_range(99) < 50);
      ri = ($urandom_range(99) < 30);
      wd = DW'($urandom);
      s_winc = wi; s_rinc = ri; s_wdata = wd;
      f_winc = wi; f_rinc = ri; f_wdata = wd;
      wacc = wi && (q.size() < 16);
      racc = ri && (q.size() > 0);
      if (racc) chk("rnd_fwft_head", 32'(f_rdata), 32'(q[0]));
      if (wi && !wacc) m_ovf = 1;
      if (ri && !racc) m_unf = 1;
      if (racc) popped = q.pop_front();
      if (wacc) q.push_back(wd);
      step();
      if (racc) chk("rnd_std_rdata", 32'(s_rdata), 32'(popped));
      chk("rnd_count", 32'(s_count), 32'(q.size()));
      chk("rnd_f_count", 32'(f_count), 32'(q.size()));
      chk("rnd_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("rnd_unf", 32'(s_unf), 32'(m_unf));
      chk("rnd_f_ovf", 32'(f_ovf), 32'(m_ovf));
      chk("rnd_f_unf", 32'(f_unf), 32'(m_unf));
    end
    s_winc = 0; s_rinc = 0; f_winc = 0; f_rinc = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo2.md
Name: sync_fifo2

Overview:
- Single-clock, parametrised FIFO; successor to the async_fifo1 family for blocks whose producer and consumer share one clock.
- Adds the following over the previous generation:
  - selectable first-word-fall-through (FWFT) read mode
  - occupancy count output
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
- Sits between a same-clock producer and consumer, e.g. a datapath stage and a bus master.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; depth = 2**ASIZE entries.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_LEVEL, 2**ASIZE-2, walmost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- wfull  out  1  FIFO full (count == 2**ASIZE).
- walmost_full  out  1  count >= AF_LEVEL.
- rinc  in  1  read request; in FWFT mode, a pop/acknowledge.
- rdata  out  DSIZE  read data.
- rempty  out  1  in standard mode, count == 0; in FWFT mode, no valid word on rdata.
- ralmost_empty  out  1  count <= AE_LEVEL.
- count  out  ASIZE+1  current occupancy, 0..2**ASIZE.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (async assert, sync release):
  - wptr, rptr and count go to 0.
  - rdata = 0, rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0, overflow = 0, underflow = 0.
  - Reset mid-operation discards all contents; memory contents need not be cleared.
- Pointers are ASIZE+1 bits binary, wrapping naturally. Full: MSBs differ and the lower bits are equal. Empty: pointers equal. count = wptr - rptr, modulo 2**(ASIZE+1).
- Write accepted iff winc && !wfull. On acceptance, mem[wptr] <= wdata and wptr increments.
- Write rejected iff winc && wfull: data dropped, pointers unchanged, overflow set to 1 until reset.
- Read accepted iff rinc && !rempty. On acceptance, rptr increments.
- Read rejected iff rinc && rempty: rptr unchanged, rdata unchanged, underflow set to 1 until reset.
- Simultaneous accepted write and read: both take effect and count is unchanged.
  - Full: the read is accepted and the write is rejected (wfull is sampled pre-edge), so overflow sets.
  - Empty: the read is rejected, underflow sets, and the write is accepted.
- All status outputs are derived from registered pointers and update on the edge following the accepting edge:
  - a write into an empty FIFO deasserts rempty one cycle later;
  - the write that fills the FIFO asserts wfull one cycle later.
- Standard mode (FWFT = 0):
  - rdata is a register loaded with mem[rptr] on an accepted read. Data is valid the cycle after the rinc edge (latency 1).
  - rdata holds its value when no read is accepted.
- FWFT mode (FWFT = 1):
  - rdata = mem[rptr] combinationally whenever rempty = 0. The head word is visible without rinc.
  - rinc consumes the shown word; the next word appears after that edge.
  - Write-to-visible latency is 1 cycle.
  - rdata is don't-care while rempty = 1.
- Threshold outputs are combinational compares on the registered count.
- AF_LEVEL and AE_LEVEL out of range (greater than depth) are illegal; the implementation contains a static assertion for this.

Decomposition:
- Package fifo_pkg:
  - default DSIZE/ASIZE constants
  - fifo_mode_e enum (STD, FWFT) used to document the FWFT parameter
  - ptr_full / ptr_empty comparison functions, also shared with the async_fifo family
- Sub-module fifo_mem: 2**ASIZE x DSIZE register array with one synchronous write port (wen, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and flag logic stay in sync_fifo2.

Test Plan:
- Reset check: rst = 1 for 3 cycles, then release → count = 0, rempty = 1, wfull = 0, ralmost_empty = 1, overflow = 0, underflow = 0.
- Fill to full (ASIZE = 4, standard mode): write 16 words 0x00..0x0F back-to-back:
  - walmost_full rises the cycle after word 14 is accepted (count = 14);
  - wfull rises after word 16 (count = 16);
  - a 17th write of 0xAA sets overflow = 1 and count stays 16;
  - draining gives rdata 0x00..0x0F, each valid one cycle after its rinc, and 0xAA never appears.
- Underflow: on an empty FIFO pulse rinc → underflow = 1, rdata unchanged, count = 0. Then write 0x5A → rempty = 0 one cycle later.
- Simultaneous read/write at count = 8: hold winc = rinc = 1 for 20 cycles with an incrementing data pattern → count stays 8 and the read sequence preserves write order across the pointer wrap-around.
- FWFT mode (FWFT = 1): write 0x3C into an empty FIFO → next cycle rempty = 0 and rdata = 0x3C with no rinc. Then write 0x3D, pulse rinc → rdata = 0x3D after the edge; a second rinc → rempty = 1.
- Random scoreboard: both modes, random winc/rinc at 50%/30% density for 5000 cycles, queue model compared on every accepted read → zero mismatches; overflow and underflow match the model exactly.
